// File: rtl/llc_bus_initiator_pkg.sv
// Shared encodings for the LLC snoop protocol and the snoop-merge / MESI-selection helpers
// used by both the bus initiator and the snoop responder.
package llc_bus_initiator_pkg;

  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_READ       = 3'd1,
    OP_WRITE      = 3'd2,
    OP_INVALIDATE = 3'd3,
    OP_RWIM       = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    SNP_HIT   = 2'd0,
    SNP_HITM  = 2'd1,
    SNP_NOHIT = 2'd2,
    SNP_RSVD  = 2'd3
  } snoop_t;

  typedef enum logic [1:0] {
    MESI_M = 2'd0,
    MESI_E = 2'd1,
    MESI_S = 2'd2,
    MESI_I = 2'd3
  } mesi_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COLLECT,
    ST_MEM,
    ST_RESP
  } state_t;

  // HITM dominates HIT; any other code (including the reserved one) reads as NOHIT.
  function automatic snoop_t merge_snoop(input logic [1:0] a, input logic [1:0] b);
    if (a == SNP_HITM || b == SNP_HITM) return SNP_HITM;
    if (a == SNP_HIT || b == SNP_HIT) return SNP_HIT;
    return SNP_NOHIT;
  endfunction

  function automatic mesi_t mesi_for(input bus_op_t op, input snoop_t merged);
    case (op)
      OP_READ:                return (merged == SNP_HIT || merged == SNP_HITM) ? MESI_S : MESI_E;
      OP_RWIM, OP_INVALIDATE: return MESI_M;
      default:                return MESI_I;
    endcase
  endfunction

endpackage

// File: rtl/llc_bus_initiator_if.sv
// Request, snoop-bus, memory and response signals of the LLC bus initiator.
interface llc_bus_initiator_if #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned NUM_SNOOPERS = 3
);
  logic                      req_valid;
  logic                      req_ready;
  logic [2:0]                req_op;
  logic [ADDR_W-1:0]         req_addr;
  logic                      bus_valid;
  logic [2:0]                bus_op;
  logic [ADDR_W-1:0]         bus_addr;
  logic [NUM_SNOOPERS-1:0]   snp_valid;
  logic [2*NUM_SNOOPERS-1:0] snp_result;
  logic                      mem_req;
  logic                      mem_ack;
  logic                      rsp_valid;
  logic [1:0]                rsp_snoop;
  logic [1:0]                rsp_mesi;
  logic                      rsp_timeout;

  modport master (
    input  req_valid, req_op, req_addr, snp_valid, snp_result, mem_ack,
    output req_ready, bus_valid, bus_op, bus_addr, mem_req,
           rsp_valid, rsp_snoop, rsp_mesi, rsp_timeout
  );

  modport slave (
    output req_valid, req_op, req_addr, snp_valid, snp_result, mem_ack,
    input  req_ready, bus_valid, bus_op, bus_addr, mem_req,
           rsp_valid, rsp_snoop, rsp_mesi, rsp_timeout
  );
endinterface

// File: rtl/llc_bus_initiator_collector.sv
// Snoop collector: tracks which peers have answered, merges their results and times out
// peers that stay silent for SNOOP_TMO cycles.
module llc_bus_initiator_collector
  import llc_bus_initiator_pkg::*;
#(
  parameter int unsigned NUM_SNOOPERS = 3,
  parameter int unsigned SNOOP_TMO    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      active_i,
  input  logic [NUM_SNOOPERS-1:0]   snp_valid_i,
  input  logic [2*NUM_SNOOPERS-1:0] snp_result_i,
  output logic                      done_o,
  output logic                      expire_o,
  output logic                      timeout_o,
  output snoop_t                    merged_o
);
  localparam int unsigned TW = $clog2(SNOOP_TMO + 1);

  logic [NUM_SNOOPERS-1:0] rcvd_q, rcvd_d;
  logic [TW-1:0]           timer_q, timer_d;
  snoop_t                  merged_q, merged_d;
  logic                    tmo_q, tmo_d;
  logic                    all_rcvd, expire;

  always_comb begin
    rcvd_d   = rcvd_q;
    timer_d  = timer_q;
    merged_d = merged_q;
    tmo_d    = tmo_q;
    all_rcvd = 1'b0;
    expire   = 1'b0;
    if (clear_i) begin
      rcvd_d   = '0;
      timer_d  = '0;
      merged_d = SNP_NOHIT;
      tmo_d    = 1'b0;
    end else if (active_i) begin
      // Only the first strobe of each peer contributes to the merge.
      for (int unsigned i = 0; i < NUM_SNOOPERS; i++) begin
        if (snp_valid_i[i] && !rcvd_q[i]) begin
          rcvd_d[i] = 1'b1;
          merged_d  = merge_snoop(merged_d, snp_result_i[2*i +: 2]);
        end
      end
      all_rcvd = &rcvd_d;
      expire   = !all_rcvd && (timer_q == TW'(SNOOP_TMO - 1));
      timer_d  = timer_q + 1'b1;
      if (expire) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcvd_q   <= '0;
      timer_q  <= '0;
      merged_q <= SNP_NOHIT;
      tmo_q    <= 1'b0;
    end else begin
      rcvd_q   <= rcvd_d;
      timer_q  <= timer_d;
      merged_q <= merged_d;
      tmo_q    <= tmo_d;
    end
  end

  assign done_o    = all_rcvd;
  assign expire_o  = expire;
  assign timeout_o = tmo_q;
  assign merged_o  = merged_q;

endmodule

// File: rtl/llc_bus_initiator.sv
// LLC snoop-protocol bus initiator: broadcasts one operation, collects peer snoop results,
// runs the memory phase and reports the merged snoop result with the resulting MESI state.
module llc_bus_initiator
  import llc_bus_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned NUM_SNOOPERS = 3,
  parameter int unsigned SNOOP_TMO    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  llc_bus_initiator_if.master   bus
);
  state_t            state_q, state_d;
  bus_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  snoop_t            rsp_snoop_q;
  mesi_t             rsp_mesi_q;
  logic              rsp_timeout_q;

  logic   col_done, col_expire, col_timeout;
  snoop_t col_merged;
  logic   req_ready, bus_valid, mem_req, rsp_valid;

  llc_bus_initiator_collector #(
    .NUM_SNOOPERS (NUM_SNOOPERS),
    .SNOOP_TMO    (SNOOP_TMO)
  ) u_collector (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == ST_ADDR),
    .active_i     (state_q == ST_COLLECT),
    .snp_valid_i  (bus.snp_valid),
    .snp_result_i (bus.snp_result),
    .done_o       (col_done),
    .expire_o     (col_expire),
    .timeout_o    (col_timeout),
    .merged_o     (col_merged)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    bus_valid = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        bus_valid = 1'b1;
        case (op_q)
          OP_READ, OP_RWIM: state_d = ST_COLLECT;
          OP_WRITE:         state_d = ST_MEM;
          default:          state_d = ST_RESP;
        endcase
      end
      ST_COLLECT: if (col_done || col_expire) state_d = ST_MEM;
      ST_MEM: begin
        mem_req = 1'b1;
        if (bus.mem_ack) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_NONE;
      addr_q        <= '0;
      rsp_snoop_q   <= SNP_NOHIT;
      rsp_mesi_q    <= MESI_I;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.req_valid) begin
        op_q   <= bus_op_t'(bus.req_op);
        addr_q <= bus.req_addr;
      end
      // Result registers update on entry to RESP and hold until the next one.
      if (state_d == ST_RESP) begin
        rsp_snoop_q   <= col_merged;
        rsp_mesi_q    <= mesi_for(op_q, col_merged);
        rsp_timeout_q <= col_timeout;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.bus_valid   = bus_valid;
  assign bus.bus_op      = op_q;
  assign bus.bus_addr    = addr_q;
  assign bus.mem_req     = mem_req;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_snoop   = rsp_snoop_q;
  assign bus.rsp_mesi    = rsp_mesi_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
